// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one imem request at a time,
// applies BTB predictions and redirects, and presents a stallable fetch packet.
module fetch_ctrl #(
    parameter int unsigned           DATA_WIDTH          = 32,
    parameter int unsigned           INSTR_WIDTH         = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC            = '0,
    parameter int unsigned           BRANCH_STALL_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [DATA_WIDTH-1:0]  redirect_pc,
    input  logic                   btb_hit,
    input  logic [DATA_WIDTH-1:0]  btb_trgt,
    output logic                   imem_req,
    output logic [DATA_WIDTH-1:0]  imem_addr,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   if_valid,
    output logic [DATA_WIDTH-1:0]  if_pc,
    output logic [INSTR_WIDTH-1:0] if_instr,
    output logic                   if_pred_taken
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam int unsigned      CNT_W    = (BRANCH_STALL_CYCLES > 1) ? $clog2(BRANCH_STALL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BRANCH_STALL_CYCLES - 1);

    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  pc_q, pc_d;
    logic                   outst_q, outst_d;
    logic                   discard_q, discard_d;
    logic [DATA_WIDTH-1:0]  tag_pc_q, tag_pc_d;
    logic                   tag_hit_q, tag_hit_d;

    logic                   out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]  out_pc_q, out_pc_d;
    logic [INSTR_WIDTH-1:0] out_instr_q, out_instr_d;
    logic                   out_pred_q, out_pred_d;

    logic                   skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0]  skid_pc_q, skid_pc_d;
    logic [INSTR_WIDTH-1:0] skid_instr_q, skid_instr_d;
    logic                   skid_pred_q, skid_pred_d;

    logic req;
    logic handshake;
    logic rsp_ok;
    logic out_free;

    // A new request is held off whenever its response might find no room.
    assign req       = (state_q == S_FETCH) & ~redirect & ~skid_valid_q
                       & ~(stall & out_valid_q & outst_q);
    assign handshake = req & imem_gnt;
    assign rsp_ok    = imem_rvalid & outst_q & ~discard_q & ~redirect;
    assign out_free  = ~out_valid_q | ~stall;

    assign imem_req      = req;
    assign imem_addr     = pc_q;
    assign if_valid      = out_valid_q;
    assign if_pc         = out_pc_q;
    assign if_instr      = out_instr_q;
    assign if_pred_taken = out_pred_q;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: state_d = S_FETCH;
            S_DRAIN: begin
                if (cnt_q == CNT_LAST) state_d = S_FETCH;
                else                   cnt_d   = cnt_q + CNT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
        if (redirect) begin
            state_d = S_DRAIN;
            cnt_d   = '0;
        end
    end

    always_comb begin
        pc_d      = pc_q;
        outst_d   = outst_q;
        discard_d = discard_q;
        tag_pc_d  = tag_pc_q;
        tag_hit_d = tag_hit_q;
        if (imem_rvalid && outst_q) begin
            outst_d   = 1'b0;
            discard_d = 1'b0;
        end
        if (redirect) begin
            pc_d      = redirect_pc;
            discard_d = outst_d;
        end else if (handshake) begin
            pc_d      = btb_hit ? btb_trgt : pc_q + DATA_WIDTH'(4);
            outst_d   = 1'b1;
            discard_d = 1'b0;
            tag_pc_d  = pc_q;
            tag_hit_d = btb_hit;
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_pc_d     = out_pc_q;
        out_instr_d  = out_instr_q;
        out_pred_d   = out_pred_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pred_d  = skid_pred_q;
        if (redirect) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_pc_d     = skid_pc_q;
                out_instr_d  = skid_instr_q;
                out_pred_d   = skid_pred_q;
                skid_valid_d = rsp_ok;
                if (rsp_ok) begin
                    skid_pc_d    = tag_pc_q;
                    skid_instr_d = imem_rdata;
                    skid_pred_d  = tag_hit_q;
                end
            end else if (rsp_ok) begin
                out_valid_d = 1'b1;
                out_pc_d    = tag_pc_q;
                out_instr_d = imem_rdata;
                out_pred_d  = tag_hit_q;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (rsp_ok) begin
            skid_valid_d = 1'b1;
            skid_pc_d    = tag_pc_q;
            skid_instr_d = imem_rdata;
            skid_pred_d  = tag_hit_q;
        end
    end

    // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            pc_q         <= RESET_PC;
            outst_q      <= 1'b0;
            discard_q    <= 1'b0;
            tag_pc_q     <= '0;
            tag_hit_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_pc_q     <= '0;
            out_instr_q  <= '0;
            out_pred_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
            skid_pred_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pc_q         <= pc_d;
            outst_q      <= outst_d;
            discard_q    <= discard_d;
            tag_pc_q     <= tag_pc_d;
            tag_hit_q    <= tag_hit_d;
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_instr_q  <= out_instr_d;
            out_pred_q   <= out_pred_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pred_q  <= skid_pred_d;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: imem responder plus a program-order packet model,
// exercised by directed scenarios and a randomized run.
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        btb_hit = 1'b0;
    logic [31:0] btb_trgt = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_pred_taken;

    fetch_ctrl #(
        .DATA_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(RESET_PC), .BRANCH_STALL_CYCLES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .btb_hit(btb_hit), .btb_trgt(btb_trgt),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .if_pred_taken(if_pred_taken)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        hit;
    } pkt_t;

    pkt_t        exp_q[$];
    logic [31:0] model_pc = RESET_PC;
    logic        rsp_pend = 1'b0;
    logic [31:0] rsp_data = '0;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic        obs_req, obs_valid, obs_pred;
    logic [31:0] obs_addr, obs_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    // One clock: drive at negedge, observe and score, then advance the model.
    task automatic tick(input logic st, input logic rd, input logic [31:0] rpc,
                        input logic g, input logic h, input logic [31:0] tg);
        pkt_t e;
        logic hs;
        @(negedge clk);
        stall = st; redirect = rd; redirect_pc = rpc;
        imem_gnt = g; btb_hit = h; btb_trgt = tg;
        imem_rvalid = rsp_pend; imem_rdata = rsp_pend ? rsp_data : 32'hDEAD_BEEF;
        #1;
        obs_req = imem_req; obs_addr = imem_addr; obs_valid = if_valid;
        obs_pc = if_pc; obs_pred = if_pred_taken;
        if (imem_req) begin
            total_cnt++;
            if (imem_addr !== model_pc)
                $display("FAIL req_addr: got %h expected %h", imem_addr, model_pc);
            else pass_cnt++;
        end
        if (if_valid && !st) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL packet_extra: got pc %h, no packet expected", if_pc);
            end else begin
                e = exp_q.pop_front();
                if ({if_pc, if_instr, if_pred_taken} !== {e.pc, e.instr, e.hit})
                    $display("FAIL packet: got pc %h instr %h pred %b expected pc %h instr %h pred %b",
                             if_pc, if_instr, if_pred_taken, e.pc, e.instr, e.hit);
                else pass_cnt++;
            end
        end
        hs = imem_req & g;
        rsp_pend = hs;
        rsp_data = mem_word(imem_addr);
        if (rd) begin
            exp_q.delete();
            model_pc = rpc;
        end else if (hs) begin
            exp_q.push_back('{pc: model_pc, instr: mem_word(model_pc), hit: h});
            model_pc = h ? tg : model_pc + 32'd4;
        end
    endtask

    task automatic run(input int n, input logic st, input logic g);
        for (int i = 0; i < n; i++) tick(st, 1'b0, '0, g, 1'b0, '0);
    endtask

    task automatic check_zero_outputs(input string tag);
        total_cnt++;
        if ({imem_req, imem_addr, if_valid, if_pc, if_instr, if_pred_taken} !== {1'b0, RESET_PC, 1'b0, 32'h0, 32'h0, 1'b0})
            $display("FAIL %s: got req %b addr %h valid %b pc %h instr %h pred %b expected all zero",
                     tag, imem_req, imem_addr, if_valid, if_pc, if_instr, if_pred_taken);
        else pass_cnt++;
    endtask

    task automatic release_reset();
        exp_q.delete();
        model_pc = RESET_PC;
        rsp_pend = 1'b0;
        {stall, redirect, imem_gnt, btb_hit, imem_rvalid} = '0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (imem_req !== 1'b0) $display("FAIL idle_no_req: got %b expected 0", imem_req);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        check_zero_outputs("reset_state");
        repeat (2) @(posedge clk);
        release_reset();
    endtask

    task automatic test_stream();
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
            if (i < 3) begin
                total_cnt++;
                if (obs_req !== 1'b1 || obs_addr !== 32'(4 * i))
                    $display("FAIL stream_addr%0d: got req %b addr %h expected req 1 addr %h",
                             i, obs_req, obs_addr, 32'(4 * i));
                else pass_cnt++;
            end
            if (i == 1) begin
                total_cnt++;
                if (obs_valid !== 1'b0) $display("FAIL early_valid: got %b expected 0", obs_valid);
                else pass_cnt++;
            end
            if (i == 2) begin
                total_cnt++;
                if (obs_valid !== 1'b1 || obs_pc !== 32'h0)
                    $display("FAIL first_packet: got valid %b pc %h expected valid 1 pc 0", obs_valid, obs_pc);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_btb();
        bit seen_target = 0;
        bit seen_pkt = 0;
        tick(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, '0);
        run(2, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            logic was_hit_cycle;
            was_hit_cycle = (model_pc == 32'h8);
            tick(1'b0, 1'b0, '0, 1'b1, was_hit_cycle, 32'h40);
            if (!seen_target && model_pc == 32'h44) begin
                seen_target = 1;
                total_cnt++;
                if (obs_addr !== 32'h40) $display("FAIL btb_target_addr: got %h expected 40", obs_addr);
                else pass_cnt++;
            end
            if (obs_valid && obs_pc == 32'h8 && !seen_pkt) begin
                seen_pkt = 1;
                total_cnt++;
                if (obs_pred !== 1'b1) $display("FAIL btb_pred_flag: got %b expected 1", obs_pred);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (!(seen_target && seen_pkt))
            $display("FAIL btb_seen: got target %0d packet %0d expected 1 1", seen_target, seen_pkt);
        else pass_cnt++;
    endtask

    task automatic test_redirect();
        run(4, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, '0);
        total_cnt++;
        if (obs_req !== 1'b0) $display("FAIL redirect_cycle_req: got %b expected 0", obs_req);
        else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
            total_cnt++;
            if (obs_req !== 1'b0 || obs_valid !== 1'b0)
                $display("FAIL drain%0d: got req %b valid %b expected 0 0", i, obs_req, obs_valid);
            else pass_cnt++;
        end
        tick(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
        total_cnt++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h100)
            $display("FAIL post_drain: got req %b addr %h expected 1 100", obs_req, obs_addr);
        else pass_cnt++;
        run(4, 1'b0, 1'b1);
    endtask

    task automatic test_stall();
        logic [31:0] held_pc;
        run(4, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
            if (i == 0) held_pc = obs_pc;
            total_cnt++;
            if (obs_req !== 1'b0 || obs_valid !== 1'b1 || obs_pc !== held_pc)
                $display("FAIL stall%0d: got req %b valid %b pc %h expected 0 1 %h",
                         i, obs_req, obs_valid, obs_pc, held_pc);
            else pass_cnt++;
        end
        run(6, 1'b0, 1'b1);
        run(5, 1'b0, 1'b0);
        total_cnt++;
        if (exp_q.size() != 0 || obs_valid !== 1'b0)
            $display("FAIL stall_drain: got %0d pending valid %b expected 0 0", exp_q.size(), obs_valid);
        else pass_cnt++;
    endtask

    task automatic test_gnt_hold();
        tick(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, '0);
        run(2, 1'b0, 1'b1);
        for (int i = 0; i < 8 && model_pc != 32'h20; i++) tick(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
            total_cnt++;
            if (obs_req !== 1'b1 || obs_addr !== 32'h20)
                $display("FAIL gnt_hold%0d: got req %b addr %h expected 1 20", i, obs_req, obs_addr);
            else pass_cnt++;
        end
        total_cnt++;
        if (obs_valid !== 1'b0) $display("FAIL gnt_hold_valid: got %b expected 0", obs_valid);
        else pass_cnt++;
        run(3, 1'b0, 1'b1);
    endtask

    task automatic test_wrap();
        tick(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b0, '0);
        run(2, 1'b0, 1'b1);
        run(6, 1'b0, 1'b1);
        total_cnt++;
        if (model_pc !== 32'h10 || obs_addr !== 32'hC)
            $display("FAIL wrap: got addr %h expected c", obs_addr);
        else pass_cnt++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            logic        st, rd, g, h;
            logic [31:0] rpc, tg;
            st  = ($urandom_range(0, 99) < 30);
            rd  = ($urandom_range(0, 99) < 3);
            g   = ($urandom_range(0, 99) < 70);
            h   = ($urandom_range(0, 99) < 12);
            rpc = $urandom & 32'h0000_FFFC;
            tg  = $urandom & 32'h0000_FFFC;
            tick(st, rd, rpc, g, h, tg);
        end
        run(6, 1'b0, 1'b0);
        total_cnt++;
        if (exp_q.size() != 0 || obs_valid !== 1'b0)
            $display("FAIL random_drain: got %0d pending valid %b expected 0 0", exp_q.size(), obs_valid);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        run(5, 1'b0, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("mid_reset");
        @(posedge clk);
        release_reset();
        tick(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
        total_cnt++;
        if (obs_req !== 1'b1 || obs_addr !== RESET_PC)
            $display("FAIL restart: got req %b addr %h expected 1 %h", obs_req, obs_addr, RESET_PC);
        else pass_cnt++;
        run(6, 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_btb();
        test_redirect();
        test_stall();
        test_gnt_hold();
        test_wrap();
        test_random();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
